clk_tick_gen: RTL

Multi-channel programmable clock-enable generator, the parametrised successor to the fixed single-output 1 kHz divider. Each of CH channels divides the system clock by a runtime-programmable divisor and produces a one-cycle tick strobe plus a 50 % square-wave output. Divisor updates go through a shadow register and a valid/ready handshake, so a period never ends early or glitches. Consumers include scan/refresh timers, debouncers, and baud/PWM prescalers.

---
 rtl/clk_tick_pkg.sv | 17 +
 rtl/clk_tick_chan.sv | 75 +++++++
 rtl/clk_tick_gen.sv | 54 +++++
 3 files changed

// File: rtl/clk_tick_pkg.sv
// Shared constants and helpers for the programmable tick generator.
// Imported by the channel and the top level.
package clk_tick_pkg;

  localparam int          CH_DEF  = 4;
  localparam int          W_DEF   = 26;
  localparam int unsigned DIV_DEF = 50_000;
  localparam int          CLAMP_W = 64;

  typedef logic [CLAMP_W-1:0] div_wide_t;

  // A zero divisor would never wrap; treat it as divide-by-one.
  function automatic div_wide_t clamp_div(input div_wide_t d);
    return (d == '0) ? div_wide_t'(1) : d;
  endfunction

endpackage

// File: rtl/clk_tick_chan.sv
// One divider channel: counter, active/shadow divisor, pending flag,
// registered tick strobe and square-wave output.
module clk_tick_chan
  import clk_tick_pkg::*;
#(
  parameter int          W           = W_DEF,
  parameter int unsigned DIV_DEFAULT = DIV_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_wr,
  input  logic [W-1:0] i_div,
  output logic         o_pend,
  output logic         o_tick,
  output logic         o_clk_out
);

  localparam logic [W-1:0] DIV_RST = W'(DIV_DEFAULT);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_div_act;
  logic [W-1:0] r_div_sh;
  logic         r_pend;
  logic         r_tick;
  logic         r_clk;

  logic [W-1:0] w_div_new;
  logic         w_wrap;

  assign w_div_new = W'(clamp_div(CLAMP_W'(i_div)));
  assign w_wrap    = (r_cnt == r_div_act - W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_div_act <= DIV_RST;
      r_div_sh  <= DIV_RST;
      r_pend    <= 1'b0;
      r_tick    <= 1'b0;
      r_clk     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_en) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          r_clk  <= ~r_clk;
          if (r_pend) begin
            r_div_act <= r_div_sh;
            r_pend    <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + W'(1);
        end
      end else begin
        r_cnt <= '0;
        if (r_pend) begin
          r_div_act <= r_div_sh;
          r_pend    <= 1'b0;
        end
      end
      // Accept only happens with pending clear, so it never races the apply.
      if (i_wr) begin
        r_div_sh <= w_div_new;
        r_pend   <= 1'b1;
      end
    end
  end

  assign o_pend    = r_pend;
  assign o_tick    = r_tick;
  assign o_clk_out = r_clk;

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel programmable clock-enable generator with
// handshaked divisor updates through per-channel shadow registers.
module clk_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int          CH          = CH_DEF,
  parameter int          W           = W_DEF,
  parameter int unsigned DIV_DEFAULT = DIV_DEF,
  localparam int         SW          = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] enable,
  input  logic          cfg_valid,
  input  logic [SW-1:0] cfg_sel,
  input  logic [W-1:0]  cfg_div,
  output logic          cfg_ready,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] clk_out
);

  localparam int NS = 1 << SW;

  logic [CH-1:0] w_pend;
  logic [CH-1:0] w_wr;
  logic [NS-1:0] w_pend_ext;
  logic          w_sel_ok;
  logic          w_accept;

  // Unused select codes read as busy so they can never be accepted.
  assign w_sel_ok   = (32'(cfg_sel) < CH);
  assign w_pend_ext = NS'(w_pend);
  assign cfg_ready  = w_sel_ok & ~w_pend_ext[cfg_sel];
  assign w_accept   = cfg_valid & cfg_ready;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign w_wr[g] = w_accept & (cfg_sel == SW'(g));

    clk_tick_chan #(
      .W           (W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_en      (enable[g]),
      .i_wr      (w_wr[g]),
      .i_div     (cfg_div),
      .o_pend    (w_pend[g]),
      .o_tick    (tick[g]),
      .o_clk_out (clk_out[g])
    );
  end

endmodule
